core_scheduler: RTL and testbench
=================================

Name: core_scheduler

Overview:
- Per-core sequencer for the lockstep SIMT core.
- Drives the 3-bit core_state that the decoder, fetcher, LSUs, ALUs and register files key off. DECODE=3'b010 is the state in which the decoder registers the instruction.
- Holds the shared program counter, waits on fetcher and per-thread LSU completion, and implements the SYNC barrier handshake toward a block-level barrier unit.
- Signals kernel completion on RET.

Parameters:
THREADS_PER_BLOCK, 4, number of lockstep threads (lanes) in the core
PC_WIDTH, 8, program counter width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
start  in  1  level; launch block from PC 0 when in IDLE
thread_enable  in  THREADS_PER_BLOCK  active-lane mask, stable while running
fetcher_state  in  3  fetcher state (IDLE=000, FETCHING=001, FETCHED=010)
lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU state, lane i at [2i+1:2i] (IDLE=00, REQUESTING=01, WAITING=10, DONE=11)
next_pc  in  PC_WIDTH*THREADS_PER_BLOCK  per-lane computed next PC, lane i at [PC_WIDTH*(i+1)-1:PC_WIDTH*i]
decoded_ret  in  1  from decoder
decoded_barrier_enable  in  1  from decoder (SYNC)
barrier_release  in  1  from block barrier unit; all cores arrived
core_state  out  3  current state
current_pc  out  PC_WIDTH  PC of instruction being processed
barrier_arrive  out  1  core is parked at a barrier
done  out  1  block finished
divergence_error  out  1  sticky; enabled lanes disagreed on next PC

Behaviour:
- One clock; reset is synchronous and active-high. All registers update on posedge clk.
- Reset: core_state=IDLE(000), current_pc=0, barrier_arrive=0, done=0, divergence_error=0. Reset mid-operation aborts immediately to these values.
- State encodings: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- IDLE: when start=1, go to FETCH next cycle; current_pc<=0, done<=0, divergence_error<=0.
- FETCH: stay until fetcher_state==FETCHED, then DECODE. Minimum 1 cycle.
- DECODE: exactly 1 cycle, then REQUEST.
- REQUEST: exactly 1 cycle, then WAIT. The decoder's registered outputs are valid from REQUEST onward.
- WAIT:
  - busy = any enabled lane with lsu_state REQUESTING or WAITING. Disabled lanes are ignored.
  - busy=1: stay.
  - busy=0 and decoded_barrier_enable=0: go to EXECUTE.
  - busy=0 and decoded_barrier_enable=1: set barrier_arrive<=1 and stay. In a cycle with barrier_arrive=1 and barrier_release=1, go to EXECUTE with barrier_arrive<=0.
  - barrier_release while barrier_arrive=0 is ignored.
- EXECUTE: exactly 1 cycle, then UPDATE.
- UPDATE:
  - decoded_ret=1: go to DONE, done<=1, PC unchanged.
  - Otherwise: current_pc <= next_pc of the lowest-index enabled lane, then FETCH.
  - If any enabled lane's next_pc differs from the selected value, divergence_error<=1 (sticky). Execution continues on the selected PC.
  - All-zero mask: use lane 0, no divergence check.
- DONE: terminal; done held at 1 until reset. start is ignored.
- Minimum non-memory instruction latency: FETCH(1)+DECODE+REQUEST+WAIT(1)+EXECUTE+UPDATE = 6 cycles.
- PC arithmetic is the lanes' responsibility; wrap-around at 2^PC_WIDTH is accepted as-is.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state localparams (IDLE..DONE)
  - fetcher state codes
  - LSU state codes
  - opcode constants (NOP..RET, SYNC=4'b1010)
- The decoder and fetcher use the same constants.
- Sub-module pc_select: combinational lowest-enabled-lane priority mux over next_pc plus mismatch compare. Outputs selected_pc and mismatch.

Test Plan:
- Reset, start=1, mask=4'b1111, fetcher FETCHED after 2 cycles, all next_pc=1 -> states 001,001,010,011,100,101,110,001; current_pc=1 on return to FETCH.
- LDR: lane 2 lsu_state WAITING for 5 cycles in WAIT, others IDLE -> core stays 100 for those 5 cycles, EXECUTE the cycle after lane 2 reaches DONE. Repeat with lane 2 disabled -> WAIT lasts 1 cycle.
- SYNC: barrier_enable=1, LSUs idle -> barrier_arrive=1 the cycle after entering WAIT; release pulsed 4 cycles later -> EXECUTE next cycle, barrier_arrive=0. A stray release pulse before arrival is ignored.
- Divergence: mask=4'b0110, next_pc={9,7,5,3} (lanes 3..0) -> current_pc=5, divergence_error=1 and remains 1 across later instructions.
- RET in UPDATE -> core_state=111, done=1 and held for 20 cycles with start toggling; reset -> IDLE, done=0.
- Reset asserted during WAIT with barrier_arrive=1 -> next cycle all outputs at reset values; a new start then runs from PC 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared encodings for the SIMT core: scheduler states, fetcher and LSU states, opcodes.
// The decoder and fetcher import the same constants.
package gpu_pkg;

    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    localparam logic [2:0] FETCHER_IDLE     = 3'b000;
    localparam logic [2:0] FETCHER_FETCHING = 3'b001;
    localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

    localparam logic [1:0] LSU_IDLE       = 2'b00;
    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;
    localparam logic [1:0] LSU_DONE       = 2'b11;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_BRNZP = 4'b0001;
    localparam logic [3:0] OP_CMP   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0110;
    localparam logic [3:0] OP_LDR   = 4'b0111;
    localparam logic [3:0] OP_STR   = 4'b1000;
    localparam logic [3:0] OP_CONST = 4'b1001;
    localparam logic [3:0] OP_SYNC  = 4'b1010;
    localparam logic [3:0] OP_RET   = 4'b1111;

endpackage

// File: rtl/core_scheduler_if.sv
// Bundle between the core scheduler and its fetcher, LSUs, decoder, lanes and barrier unit.
// master = scheduler side, slave = the surrounding core/block logic.
interface core_scheduler_if #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8
);
    logic [2:0]                            fetcher_state;
    logic [2*THREADS_PER_BLOCK-1:0]        lsu_state;
    logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc;
    logic                                  decoded_ret;
    logic                                  decoded_barrier_enable;
    logic                                  barrier_release;
    logic [2:0]                            core_state;
    logic [PC_WIDTH-1:0]                   current_pc;
    logic                                  barrier_arrive;

    modport master (
        input  fetcher_state, lsu_state, next_pc, decoded_ret,
               decoded_barrier_enable, barrier_release,
        output core_state, current_pc, barrier_arrive
    );

    modport slave (
        output fetcher_state, lsu_state, next_pc, decoded_ret,
               decoded_barrier_enable, barrier_release,
        input  core_state, current_pc, barrier_arrive
    );
endinterface

// File: rtl/core_scheduler_pc_select.sv
// Picks the next PC from the lowest-index enabled lane and flags lanes that disagree.
// With no lanes enabled, lane 0 is selected and no mismatch is reported.
module pc_select #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8
) (
    input  logic [THREADS_PER_BLOCK-1:0]          thread_enable,
    input  logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [PC_WIDTH-1:0]                   selected_pc,
    output logic                                  mismatch
);
    logic found;

    always_comb begin
        selected_pc = next_pc[PC_WIDTH-1:0];
        found       = 1'b0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] && !found) begin
                selected_pc = next_pc[PC_WIDTH*i +: PC_WIDTH];
                found       = 1'b1;
            end
        end
        mismatch = 1'b0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] && (next_pc[PC_WIDTH*i +: PC_WIDTH] != selected_pc))
                mismatch = 1'b1;
        end
    end
endmodule

// File: rtl/core_scheduler.sv
// Per-core sequencer: steps core_state, holds the shared PC, waits on fetcher/LSUs,
// runs the SYNC barrier handshake and reports kernel completion.
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [THREADS_PER_BLOCK-1:0] thread_enable,
    core_scheduler_if.master             bus,
    output logic                         done,
    output logic                         divergence_error
);
    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                arrive_q, arrive_d;
    logic                done_q, done_d;
    logic                div_q, div_d;
    logic [PC_WIDTH-1:0] selected_pc;
    logic                mismatch;
    logic                busy;

    pc_select #(
        .THREADS_PER_BLOCK (THREADS_PER_BLOCK),
        .PC_WIDTH          (PC_WIDTH)
    ) u_pc_select (
        .thread_enable (thread_enable),
        .next_pc       (bus.next_pc),
        .selected_pc   (selected_pc),
        .mismatch      (mismatch)
    );

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] &&
                ((bus.lsu_state[2*i +: 2] == LSU_REQUESTING) ||
                 (bus.lsu_state[2*i +: 2] == LSU_WAITING)))
                busy = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        arrive_d = arrive_q;
        done_d   = done_q;
        div_d    = div_q;
        case (state_q)
            CORE_IDLE: begin
                if (start) begin
                    state_d = CORE_FETCH;
                    pc_d    = '0;
                    done_d  = 1'b0;
                    div_d   = 1'b0;
                end
            end
            CORE_FETCH: begin
                if (bus.fetcher_state == FETCHER_FETCHED)
                    state_d = CORE_DECODE;
            end
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            CORE_WAIT: begin
                // Once parked, only the release can move us; a release seen before arrival is dropped.
                if (arrive_q) begin
                    if (bus.barrier_release) begin
                        arrive_d = 1'b0;
                        state_d  = CORE_EXECUTE;
                    end
                end else if (!busy) begin
                    if (bus.decoded_barrier_enable)
                        arrive_d = 1'b1;
                    else
                        state_d = CORE_EXECUTE;
                end
            end
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                if (bus.decoded_ret) begin
                    state_d = CORE_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = CORE_FETCH;
                    pc_d    = selected_pc;
                    if (mismatch)
                        div_d = 1'b1;
                end
            end
            default: state_d = CORE_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CORE_IDLE;
            pc_q     <= '0;
            arrive_q <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            arrive_q <= arrive_d;
            done_q   <= done_d;
            div_q    <= div_d;
        end
    end

    assign bus.core_state     = state_q;
    assign bus.current_pc     = pc_q;
    assign bus.barrier_arrive = arrive_q;
    assign done               = done_q;
    assign divergence_error   = div_q;
endmodule

// File: tb/tb_core_scheduler.sv
// Directed-vector bench for core_scheduler: sequencing, LSU waits, barrier, divergence, RET, reset.
module tb_core_scheduler;
    import gpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] thread_enable;
    logic       done;
    logic       divergence_error;
    int         vectors = 0;
    int         miscompares = 0;

    core_scheduler_if #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8)) bus ();

    core_scheduler #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .thread_enable    (thread_enable),
        .bus              (bus.master),
        .done             (done),
        .divergence_error (divergence_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_next_pc(input logic [7:0] l3, input logic [7:0] l2,
                               input logic [7:0] l1, input logic [7:0] l0);
        bus.next_pc = {l3, l2, l1, l0};
    endtask

    // Drives FETCH -> DECODE -> REQUEST -> WAIT; leaves the core sitting in WAIT.
    task automatic fetch_to_wait();
        bus.fetcher_state = FETCHER_FETCHED;
        tick();
        bus.fetcher_state = FETCHER_IDLE;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; thread_enable = 4'hF;
        bus.fetcher_state = FETCHER_IDLE; bus.lsu_state = '0; bus.next_pc = '0;
        bus.decoded_ret = 1'b0; bus.decoded_barrier_enable = 1'b0; bus.barrier_release = 1'b0;
        tick(); tick();
        vectors++;
        if (bus.core_state !== CORE_IDLE || bus.current_pc !== 8'd0 || bus.barrier_arrive !== 1'b0 ||
            done !== 1'b0 || divergence_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: state=%b pc=%0d arrive=%b done=%b div=%b, required 000/0/0/0/0",
                     bus.core_state, bus.current_pc, bus.barrier_arrive, done, divergence_error);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [2:0] exp_seq [0:7];
        exp_seq = '{3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001};
        set_next_pc(8'd1, 8'd1, 8'd1, 8'd1);
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (bus.core_state !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL basic_seq[%0d]: state=%b, required %b", i, bus.core_state, exp_seq[i]);
            end
            if (i == 0) begin start = 1'b0; bus.fetcher_state = FETCHER_FETCHING; end
            if (i == 1) bus.fetcher_state = FETCHER_FETCHED;
            if (i == 2) bus.fetcher_state = FETCHER_IDLE;
        end
        vectors++;
        if (bus.current_pc !== 8'd1) begin
            miscompares++;
            $display("FAIL basic_pc: pc=%0d, required 1", bus.current_pc);
        end
    endtask

    task automatic test_ldr();
        set_next_pc(8'd2, 8'd2, 8'd2, 8'd2);
        bus.lsu_state = {LSU_IDLE, LSU_WAITING, LSU_IDLE, LSU_IDLE};
        fetch_to_wait();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            vectors++;
            if (bus.core_state !== CORE_WAIT) begin
                miscompares++;
                $display("FAIL ldr_wait[%0d]: state=%b, required 100", i, bus.core_state);
            end
        end
        bus.lsu_state = {LSU_IDLE, LSU_DONE, LSU_IDLE, LSU_IDLE};
        tick();
        vectors++;
        if (bus.core_state !== CORE_EXECUTE) begin
            miscompares++;
            $display("FAIL ldr_exec: state=%b, required 101", bus.core_state);
        end
        bus.lsu_state = '0;
        tick(); tick();
        vectors++;
        if (bus.core_state !== CORE_FETCH || bus.current_pc !== 8'd2) begin
            miscompares++;
            $display("FAIL ldr_pc: state=%b pc=%0d, required 001/2", bus.core_state, bus.current_pc);
        end
        thread_enable = 4'b1011;
        set_next_pc(8'd3, 8'hAA, 8'd3, 8'd3);
        bus.lsu_state = {LSU_IDLE, LSU_WAITING, LSU_IDLE, LSU_IDLE};
        fetch_to_wait();
        tick();
        vectors++;
        if (bus.core_state !== CORE_EXECUTE) begin
            miscompares++;
            $display("FAIL ldr_masked_exec: state=%b, required 101", bus.core_state);
        end
        tick(); tick();
        vectors++;
        if (bus.current_pc !== 8'd3 || divergence_error !== 1'b0) begin
            miscompares++;
            $display("FAIL ldr_masked_pc: pc=%0d div=%b, required 3/0", bus.current_pc, divergence_error);
        end
        bus.lsu_state = '0;
        thread_enable = 4'hF;
    endtask

    task automatic test_sync();
        set_next_pc(8'd4, 8'd4, 8'd4, 8'd4);
        bus.decoded_barrier_enable = 1'b1;
        fetch_to_wait();
        bus.barrier_release = 1'b1;
        tick();
        bus.barrier_release = 1'b0;
        vectors++;
        if (bus.core_state !== CORE_WAIT || bus.barrier_arrive !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_arrive: state=%b arrive=%b, required 100/1", bus.core_state, bus.barrier_arrive);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.core_state !== CORE_WAIT || bus.barrier_arrive !== 1'b1) begin
                miscompares++;
                $display("FAIL sync_park[%0d]: state=%b arrive=%b, required 100/1",
                         i, bus.core_state, bus.barrier_arrive);
            end
        end
        bus.barrier_release = 1'b1;
        tick();
        bus.barrier_release = 1'b0;
        bus.decoded_barrier_enable = 1'b0;
        vectors++;
        if (bus.core_state !== CORE_EXECUTE || bus.barrier_arrive !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_release: state=%b arrive=%b, required 101/0", bus.core_state, bus.barrier_arrive);
        end
        tick(); tick();
        vectors++;
        if (bus.core_state !== CORE_FETCH || bus.current_pc !== 8'd4) begin
            miscompares++;
            $display("FAIL sync_pc: state=%b pc=%0d, required 001/4", bus.core_state, bus.current_pc);
        end
    endtask

    task automatic test_divergence();
        thread_enable = 4'b0110;
        set_next_pc(8'd9, 8'd7, 8'd5, 8'd3);
        fetch_to_wait();
        tick(); tick(); tick();
        vectors++;
        if (bus.current_pc !== 8'd5 || divergence_error !== 1'b1) begin
            miscompares++;
            $display("FAIL div_detect: pc=%0d div=%b, required 5/1", bus.current_pc, divergence_error);
        end
        thread_enable = 4'hF;
        set_next_pc(8'd6, 8'd6, 8'd6, 8'd6);
        fetch_to_wait();
        tick(); tick(); tick();
        vectors++;
        if (bus.current_pc !== 8'd6 || divergence_error !== 1'b1) begin
            miscompares++;
            $display("FAIL div_sticky: pc=%0d div=%b, required 6/1", bus.current_pc, divergence_error);
        end
    endtask

    task automatic test_ret();
        bus.decoded_ret = 1'b1;
        set_next_pc(8'h33, 8'h33, 8'h33, 8'h33);
        fetch_to_wait();
        tick(); tick(); tick();
        vectors++;
        if (bus.core_state !== CORE_DONE || done !== 1'b1 || bus.current_pc !== 8'd6) begin
            miscompares++;
            $display("FAIL ret_done: state=%b done=%b pc=%0d, required 111/1/6",
                     bus.core_state, done, bus.current_pc);
        end
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            tick();
            vectors++;
            if (bus.core_state !== CORE_DONE || done !== 1'b1 || bus.current_pc !== 8'd6) begin
                miscompares++;
                $display("FAIL ret_hold[%0d]: state=%b done=%b pc=%0d, required 111/1/6",
                         i, bus.core_state, done, bus.current_pc);
            end
        end
        start = 1'b0;
        bus.decoded_ret = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (bus.core_state !== CORE_IDLE || done !== 1'b0 || divergence_error !== 1'b0 || bus.current_pc !== 8'd0) begin
            miscompares++;
            $display("FAIL ret_reset: state=%b done=%b div=%b pc=%0d, required 000/0/0/0",
                     bus.core_state, done, divergence_error, bus.current_pc);
        end
    endtask

    task automatic test_reset_in_barrier();
        set_next_pc(8'h10, 8'h10, 8'h10, 8'h10);
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.decoded_barrier_enable = 1'b1;
        fetch_to_wait();
        tick();
        vectors++;
        if (bus.core_state !== CORE_WAIT || bus.barrier_arrive !== 1'b1) begin
            miscompares++;
            $display("FAIL rstbar_arrive: state=%b arrive=%b, required 100/1", bus.core_state, bus.barrier_arrive);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.decoded_barrier_enable = 1'b0;
        vectors++;
        if (bus.core_state !== CORE_IDLE || bus.current_pc !== 8'd0 || bus.barrier_arrive !== 1'b0 ||
            done !== 1'b0 || divergence_error !== 1'b0) begin
            miscompares++;
            $display("FAIL rstbar_abort: state=%b pc=%0d arrive=%b done=%b div=%b, required 000/0/0/0/0",
                     bus.core_state, bus.current_pc, bus.barrier_arrive, done, divergence_error);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (bus.core_state !== CORE_FETCH || bus.current_pc !== 8'd0) begin
            miscompares++;
            $display("FAIL rstbar_restart: state=%b pc=%0d, required 001/0", bus.core_state, bus.current_pc);
        end
        fetch_to_wait();
        tick(); tick(); tick();
        vectors++;
        if (bus.core_state !== CORE_FETCH || bus.current_pc !== 8'h10 || divergence_error !== 1'b0) begin
            miscompares++;
            $display("FAIL rstbar_run: state=%b pc=%0d div=%b, required 001/16/0",
                     bus.core_state, bus.current_pc, divergence_error);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ldr();
        test_sync();
        test_divergence();
        test_ret();
        test_reset_in_barrier();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
